fir_stream_master: RTL

FIR_STREAM_MASTER -- requirements
Module: fir_stream_master

---
 rtl/fir_stream_pkg.sv | 14 +
 rtl/fir_result_fifo.sv | 62 ++++++
 rtl/fir_stream_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: shared FSM state codes and the FIFO count-width helper for fir_stream_master
package fir_stream_pkg;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_PRESENT     = 2'd1;
    localparam logic [1:0] ST_WAIT_RESULT = 2'd2;
    localparam logic [1:0] ST_ACK         = 2'd3;

    // The occupancy counter must represent 0..depth, hence one bit more than the pointers.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_result_fifo.sv
// fir_result_fifo: first-word fall-through result FIFO between the filter and the downstream stream
//   i_clk, i_rst          clock, synchronous active-high reset (empties the FIFO)
//   i_push, iv_wdata      write request and data; ignored when full
//   i_pop, ov_rdata       read request; ov_rdata shows the head entry (0 when empty)
//   o_full, o_empty       occupancy flags
//   ov_count              number of stored entries, 0..FIFO_DEPTH
module fir_result_fifo
    import fir_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_push,
    input  logic [DATA_WIDTH-1:0]                 iv_wdata,
    input  logic                                  i_pop,
    output logic [DATA_WIDTH-1:0]                 ov_rdata,
    output logic                                  o_full,
    output logic                                  o_empty,
    output logic [count_width(FIFO_DEPTH)-1:0]    ov_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = count_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    // Pointers are exactly log2(depth) bits wide, so they wrap modulo the depth on their own.
    always_comb begin
        o_full   = count_q == CW'(FIFO_DEPTH);
        o_empty  = count_q == '0;
        push_ok  = i_push && !o_full;
        pop_ok   = i_pop && !o_empty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        ov_rdata = o_empty ? '0 : mem_q[rd_ptr_q];
        ov_count = count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= iv_wdata;
    end

endmodule

// File: rtl/fir_stream_master.sv
// fir_stream_master: feeds one sample at a time to an external FIR filter and queues its results
//   i_clk, i_rst                                   clock, synchronous active-high reset
//   iv_s_data, i_s_valid, o_s_ready                upstream sample stream (valid/ready)
//   ov_fir_din, o_fir_din_valid, i_fir_ready       sample to filter; i_fir_ready is a consume pulse
//   iv_fir_dout, i_fir_dout_valid, o_fir_dout_ready result from filter; o_fir_dout_ready is an ack pulse
//   ov_m_data, o_m_valid, i_m_ready                downstream result stream (valid/ready, FWFT)
//   ov_fifo_count, o_busy, o_timeout               status
// Optional feature: define FIR_STREAM_TIMEOUT_EN to enable the result watchdog (TIMEOUT_CYCLES);
// otherwise o_timeout is tied low and the FSM waits for a result indefinitely.
module fir_stream_master
    import fir_stream_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [DATA_WIDTH-1:0]                 iv_s_data,
    input  logic                                  i_s_valid,
    output logic                                  o_s_ready,
    output logic [DATA_WIDTH-1:0]                 ov_fir_din,
    output logic                                  o_fir_din_valid,
    input  logic                                  i_fir_ready,
    input  logic [DATA_WIDTH-1:0]                 iv_fir_dout,
    input  logic                                  i_fir_dout_valid,
    output logic                                  o_fir_dout_ready,
    output logic [DATA_WIDTH-1:0]                 ov_m_data,
    output logic                                  o_m_valid,
    input  logic                                  i_m_ready,
    output logic [count_width(FIFO_DEPTH)-1:0]    ov_fifo_count,
    output logic                                  o_busy,
    output logic                                  o_timeout
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  accept, push, full, empty, expire;

    // Only IDLE accepts, and only with a free FIFO slot, so a captured result can never overflow.
    assign o_s_ready        = (state_q == ST_IDLE) && !full && !i_rst;
    assign accept           = i_s_valid && o_s_ready;
    assign ov_fir_din       = din_q;
    assign o_fir_din_valid  = state_q == ST_PRESENT;
    assign o_fir_dout_ready = state_q == ST_ACK;
    assign o_busy           = state_q != ST_IDLE;
    assign o_m_valid        = !empty;

    // i_fir_dout_valid is a level and is only looked at in WAIT_RESULT; a result arriving in the
    // same cycle the watchdog expires still wins.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    din_d   = iv_s_data;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_fir_ready) state_d = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                if (i_fir_dout_valid) begin
                    push    = 1'b1;
                    state_d = ST_ACK;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
        end
    end

`ifdef FIR_STREAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    // The counter holds the number of WAIT_RESULT cycles already spent; it expires on the
    // TIMEOUT_CYCLES-th one and is cleared whenever the FSM is elsewhere.
    always_comb begin
        expire    = (state_q == ST_WAIT_RESULT) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = ((state_q == ST_WAIT_RESULT) && !i_fir_dout_valid && !expire) ? tmo_cnt_q + 1'b1 : '0;
        timeout_d = timeout_q || (expire && !i_fir_dout_valid);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    fir_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (push),
        .iv_wdata (iv_fir_dout),
        .i_pop    (i_m_ready),
        .ov_rdata (ov_m_data),
        .o_full   (full),
        .o_empty  (empty),
        .ov_count (ov_fifo_count)
    );

endmodule
